alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked, multi-cycle ALU; successor to the fixed 4-bit combinational ALU.
//  Adds WIDTH generalisation, signed compare, iterative shifts and multiply, result flags and
//  valid/ready flow control on both sides, so it can sit between a decode stage and writeback.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal values are 4..32.
//  SHW    $clog2(WIDTH)  shift-amount width; derived from WIDTH, never overridden.
// PORTS
//  clk        in   1      clock; all state is updated on the rising edge.
//  rst        in   1      reset, asynchronous and active-high.
//  in_valid   in   1      the operand/op bundle is valid.
//  in_ready   out  1      the block can accept a new op.
//  op         in   4      operation code (see BEHAVIOUR).
//  a, b       in   WIDTH  operands.
//  out_valid  out  1      result and flags are valid.
//  out_ready  in   1      the consumer takes the result.
//  result     out  WIDTH  operation result.
//  flag_c     out  1      carry out (add) or borrow (sub).
//  flag_v     out  1      signed overflow (add/sub only).
//  flag_z     out  1      result is zero.
//  flag_n     out  1      result[WIDTH-1].
//  err        out  1      illegal op code.
// BEHAVIOUR
//  Reset (async, takes effect immediately):
//   - state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0; err=0.
//   - An in-flight op is discarded silently.
//  FSM: IDLE -> (BUSY) -> DONE -> IDLE.
//   - in_ready is 1 only in IDLE. The op is accepted on an edge where in_valid & in_ready.
//   - At acceptance, a, b and op are latched. Input changes after that edge are ignored.
//   - Single-cycle ops: IDLE -> DONE; out_valid is 1 on the cycle after acceptance.
//   - Shift ops: IDLE -> BUSY. BUSY moves 1 bit per cycle for sh=b[SHW-1:0] cycles, then DONE.
//     out_valid asserts sh+1 cycles after acceptance. When sh=0 the op goes straight to DONE
//     (latency 1).
//   - MUL: shift-add over WIDTH BUSY cycles. out_valid asserts WIDTH+1 cycles after acceptance.
//   - DONE: out_valid=1. result, flags and err stay stable until out_valid & out_ready, then
//     the FSM returns to IDLE.
//   - No new op is accepted in the handover cycle. Peak throughput is 1 op per 2 cycles.
//   - out_valid drops on the edge after the handshake. result and flags keep their last values.
//  Op codes (unsigned unless stated; results truncated to WIDTH):
//   - 0 ADD  a+b; flag_c = carry out of the MSB.
//   - 1 SUB  a-b; flag_c = borrow (a<b unsigned).
//   - 0/1 flag_v = two's-complement overflow.
//   - 2 NOT ~a;  3 AND;  4 OR;  5 XOR.
//   - 6 SLTU  result = {0..,a<b}.
//   - 7 EQ    result = {0..,a==b}.
//   - 8 SLT   signed compare; result = {0..,a<b}.
//   - 9 SLL;  10 SRL;  11 SRA (shift in a[WIDTH-1]). Shift amount = b[SHW-1:0].
//   - 12 MUL  low WIDTH bits of a*b.
//   - 13..15 illegal: result = all ones; err=1; latency 1.
//  Flags:
//   - flag_z and flag_n follow the final result for every op, including illegal ones.
//   - flag_c and flag_v are 0 for every op other than ADD and SUB.
//   - err is 0 for every legal op.
// TESTING (WIDTH=8 unless noted)
//  1. ADD a=FF b=01 -> result=00, c=1, z=1, v=0; out_valid 1 cycle after accept.
//  2. SUB a=80 b=01 -> result=7F, v=1, c=0. SLT a=FF b=01 -> 01. SLTU a=FF b=01 -> 00.
//  3. SRA a=90 b=03 -> F2, out_valid 4 cycles after accept.
//     SLL b=00 -> result=a, latency 1.
//  4. MUL a=0D b=0B -> 8F, n=1, latency 9.
//     Hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
//  5. Assert rst 3 cycles into a MUL -> out_valid=0, in_ready=1 immediately.
//     Next ADD 02+03 -> 05.
//  6. op=4'hD -> result=FF, err=1, z=0, n=1.
//     Also rerun test 1 with WIDTH=4 (F+1 -> 0, c=1).

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts,
// shift-add multiply, registered result and flags held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;   // wide enough to hold WIDTH for the multiply count
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_EQ   = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work;     // shift operand, or multiplicand during MUL
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [SHW-1:0]   sh;
    logic             accept, multi, last_step, op_q_shift;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_result, step;
    logic             alu_c, alu_v, alu_err;
    logic             fin_load;
    logic [WIDTH-1:0] fin_result;
    logic             fin_c, fin_v, fin_err;

    assign sh         = b[SHW-1:0];
    assign accept     = in_valid && (state == IDLE);
    assign multi      = (op == OP_MUL) ||
                        (((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA)) && (sh != '0));
    assign last_step  = (state == BUSY) && (cnt == CW'(1));
    assign op_q_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);

    // Single-cycle results, computed straight from the live inputs at acceptance.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_err    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                alu_c      = sum[WIDTH];
                alu_v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_result = diff[WIDTH-1:0];
                alu_c      = diff[WIDTH];
                alu_v      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_NOT:  alu_result = ~a;
            OP_AND:  alu_result = a & b;
            OP_OR:   alu_result = a | b;
            OP_XOR:  alu_result = a ^ b;
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_EQ:   alu_result = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL, OP_SRL, OP_SRA: alu_result = a;   // only reaches here with a zero shift
            OP_MUL:  alu_result = '0;
            default: begin
                alu_result = '1;
                alu_err    = 1'b1;
            end
        endcase
    end

    // One iteration of the serial datapath: a 1-bit shift, or one shift-add partial product.
    always_comb begin
        case (op_q)
            OP_SLL:  step = work << 1;
            OP_SRL:  step = work >> 1;
            OP_SRA:  step = {work[MSB], work[WIDTH-1:1]};
            default: step = acc + (mplier[0] ? work : '0);
        endcase
    end

    always_comb begin
        fin_load   = 1'b0;
        fin_result = alu_result;
        fin_c      = alu_c;
        fin_v      = alu_v;
        fin_err    = alu_err;
        if (accept && !multi) begin
            fin_load = 1'b1;
        end else if (last_step) begin
            fin_load   = 1'b1;
            fin_result = step;
            fin_c      = 1'b0;
            fin_v      = 1'b0;
            fin_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = multi ? BUSY : DONE;
            end
            BUSY: if (cnt == CW'(1)) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all of them see the pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            work   <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= op;
                work   <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= (op == OP_MUL) ? CW'(WIDTH) : CW'(sh);
            end else if (state == BUSY) begin
                cnt <= cnt - CW'(1);
                if (op_q_shift) begin
                    work <= step;
                end else begin
                    acc    <= step;
                    work   <= work << 1;
                    mplier <= mplier >> 1;
                end
            end
            if (fin_load) begin
                result <= fin_result;
                flag_c <= fin_c;
                flag_v <= fin_v;
                flag_z <= (fin_result == '0);
                flag_n <= fin_result[MSB];
                err    <= fin_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: arithmetic model of every op, a per-cycle output
// comparator, latency and hold checks, async reset mid-multiply, and a WIDTH=4 instance.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [3:0] op;
    logic [7:0] a, b, result;
    logic       flag_c, flag_v, flag_z, flag_n, err;

    logic       in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0] op4, a4, b4, result4;
    logic       flag_c4, flag_v4, flag_z4, flag_n4, err4;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .err(err)
    );

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .op(op4),
        .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
        .flag_c(flag_c4), .flag_v(flag_v4), .flag_z(flag_z4), .flag_n(flag_n4), .err(err4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_r;
    logic       exp_c, exp_v, exp_e;
    int         exp_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    endtask

    // Expected outcome of one op on the 8-bit instance, from plain integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int sx, sy, full, sh;
        sx = $signed(x);
        sy = $signed(y);
        sh = int'(y[2:0]);
        full = 0;
        exp_c = 1'b0; exp_v = 1'b0; exp_e = 1'b0; exp_lat = 1;
        case (o)
            4'd0: begin
                full  = int'(x) + int'(y);
                exp_r = full[7:0];
                exp_c = (full > 255);
                exp_v = (sx + sy > 127) || (sx + sy < -128);
            end
            4'd1: begin
                full  = int'(x) - int'(y);
                exp_r = full[7:0];
                exp_c = (x < y);
                exp_v = (sx - sy > 127) || (sx - sy < -128);
            end
            4'd2:  exp_r = ~x;
            4'd3:  exp_r = x & y;
            4'd4:  exp_r = x | y;
            4'd5:  exp_r = x ^ y;
            4'd6:  exp_r = (x < y) ? 8'd1 : 8'd0;
            4'd7:  exp_r = (x == y) ? 8'd1 : 8'd0;
            4'd8:  exp_r = (sx < sy) ? 8'd1 : 8'd0;
            4'd9:  begin exp_r = x << sh; exp_lat = sh + 1; end
            4'd10: begin exp_r = x >> sh; exp_lat = sh + 1; end
            4'd11: begin exp_r = $signed(x) >>> sh; exp_lat = sh + 1; end
            4'd12: begin
                full    = int'(x) * int'(y);
                exp_r   = full[7:0];
                exp_lat = 9;
            end
            default: begin exp_r = 8'hFF; exp_e = 1'b1; end
        endcase
    endfunction

    // Whenever a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("cmp_result", result, exp_r);
            check("cmp_c", flag_c, exp_c);
            check("cmp_v", flag_v, exp_v);
            check("cmp_z", flag_z, exp_r == 8'h00);
            check("cmp_n", flag_n, exp_r[7]);
            check("cmp_err", err, exp_e);
            check("cmp_in_ready_busy", in_ready, 1'b0);
        end
    end

    task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input int hold, output int lat);
        @(negedge clk);
        check({name, "_in_ready"}, in_ready, 1'b1);
        model(o, x, y);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'd2; a = ~x; b = ~y;
        lat = 1;
        while (!out_valid && lat <= 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_out_valid_drop"}, out_valid, 1'b0);
        check({name, "_result_kept"}, result, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; op4 = '0; a4 = '0; b4 = '0;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_flags", {flag_c, flag_v, flag_z, flag_n, err}, 5'b0);
        check("rst4_out_valid", out_valid4, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ff_01", 4'd0, 8'hFF, 8'h01, 0, lat);
        check("add_lit_result", result, 8'h00);
        check("add_lit_cvz", {flag_c, flag_v, flag_z}, 3'b101);
        check("add_lit_lat", lat, 1);

        run_op("sub_80_01", 4'd1, 8'h80, 8'h01, 0, lat);
        check("sub_lit_result", result, 8'h7F);
        check("sub_lit_vc", {flag_v, flag_c}, 2'b10);

        run_op("slt", 4'd8, 8'hFF, 8'h01, 0, lat);
        check("slt_lit", result, 8'h01);
        run_op("sltu", 4'd6, 8'hFF, 8'h01, 0, lat);
        check("sltu_lit", result, 8'h00);

        run_op("sra_90_3", 4'd11, 8'h90, 8'h03, 0, lat);
        check("sra_lit_result", result, 8'hF2);
        check("sra_lit_lat", lat, 4);

        run_op("sll_0", 4'd9, 8'h5A, 8'h00, 0, lat);
        check("sll0_lit_result", result, 8'h5A);
        check("sll0_lit_lat", lat, 1);

        run_op("mul_0d_0b", 4'd12, 8'h0D, 8'h0B, 5, lat);
        check("mul_lit_result", result, 8'h8F);
        check("mul_lit_n", flag_n, 1'b1);
        check("mul_lit_lat", lat, 9);

        run_op("illegal_d", 4'hD, 8'h12, 8'h34, 0, lat);
        check("ill_lit", {result, err, flag_z, flag_n}, {8'hFF, 3'b101});

        run_op("add_ovf", 4'd0, 8'h7F, 8'h01, 0, lat);
        run_op("sub_borrow", 4'd1, 8'h01, 8'h02, 0, lat);
        run_op("not", 4'd2, 8'h0F, 8'h00, 0, lat);
        run_op("and", 4'd3, 8'hF0, 8'h3C, 0, lat);
        run_op("or", 4'd4, 8'hA0, 8'h05, 1, lat);
        run_op("xor", 4'd5, 8'hA5, 8'h3C, 0, lat);
        check("xor_lit", result, 8'h99);
        run_op("eq", 4'd7, 8'h33, 8'h33, 0, lat);
        run_op("srl_7", 4'd10, 8'hF0, 8'h07, 0, lat);
        check("srl_lit", {result, 8'(lat)}, {8'h01, 8'd8});
        run_op("sll_hi_b", 4'd9, 8'h81, 8'h0B, 0, lat);
        check("sll_hi_b_lit", result, 8'h08);
        run_op("sra_pos", 4'd11, 8'h7F, 8'h02, 0, lat);
        run_op("mul_ff_ff", 4'd12, 8'hFF, 8'hFF, 0, lat);
        check("mul_ff_lit", result, 8'h01);
        run_op("illegal_f", 4'hF, 8'h00, 8'h00, 2, lat);

        // Reset three cycles into a multiply discards it.
        @(negedge clk);
        model(4'd12, 8'h0D, 8'h0B);
        in_valid = 1'b1; op = 4'd12; a = 8'h0D; b = 8'h0B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_result", result, 8'h00);
        check("rst_mid_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op("add_after_rst", 4'd0, 8'h02, 8'h03, 0, lat);
        check("add_after_rst_lit", result, 8'h05);

        // WIDTH=4 carry-out wrap.
        @(negedge clk);
        check("w4_in_ready", in_ready4, 1'b1);
        in_valid4 = 1'b1; op4 = 4'd0; a4 = 4'hF; b4 = 4'h1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        check("w4_out_valid", out_valid4, 1'b1);
        check("w4_result", result4, 4'h0);
        check("w4_flags", {flag_c4, flag_v4, flag_z4, flag_n4, err4}, 5'b10100);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("w4_out_valid_drop", out_valid4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
